// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq: handshaked WIDTH-bit ALU with registered results, iterative multiply/divide.
// Define CPU_ALU_DIV_EN to build the restoring divider for ops 1110/1111.
module cpu_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW = SHW + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, b, hi_n, lo_n, r1, rn;
  logic [WIDTH:0] add_w, sub_w, mul_s;
  logic [SHW-1:0] amt;
  logic c1, v1, iter, accept, last, sel_hi;
  assign in_ready = !reset && (state == IDLE || (state == DONE && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign last = state == BUSY && cnt == CW'(1);
`ifdef CPU_ALU_DIV_EN
  assign iter = in_op[3:2] == 2'b11;
`else
  assign iter = in_op[3:1] == 3'b110;
`endif
  always_comb begin
    state_n = accept ? (iter ? BUSY : DONE) : last ? DONE : (state == DONE && out_ready) ? IDLE : state;
  end
  assign amt = in_y[SHW-1:0];
  assign add_w = {1'b0, in_x} + {1'b0, in_y};
  assign sub_w = {1'b0, in_x} - {1'b0, in_y};
  always_comb begin
    r1 = '0;
    c1 = 1'b0;
    v1 = 1'b0;
    case (in_op)
      4'b0000: r1 = in_x & in_y;
      4'b0001: r1 = in_x | in_y;
      4'b0010: r1 = in_x ^ in_y;
      4'b0011: r1 = ~in_x;
      4'b0100: begin
        r1 = add_w[WIDTH-1:0];
        c1 = add_w[WIDTH];
        v1 = (in_x[WIDTH-1] == in_y[WIDTH-1]) && (add_w[WIDTH-1] != in_x[WIDTH-1]);
      end
      4'b0101: begin
        r1 = sub_w[WIDTH-1:0];
        c1 = sub_w[WIDTH];
        v1 = (in_x[WIDTH-1] != in_y[WIDTH-1]) && (sub_w[WIDTH-1] != in_x[WIDTH-1]);
      end
      4'b0110: r1 = WIDTH'($signed(in_x) < $signed(in_y));
      4'b0111: r1 = WIDTH'(in_x < in_y);
      4'b1000: r1 = in_x << amt;
      4'b1001: r1 = in_x >> amt;
      4'b1010: r1 = (in_x << amt) | (in_x >> (WIDTH - int'(amt)));
      4'b1011: r1 = (in_x >> amt) | (in_x << (WIDTH - int'(amt)));
      default: r1 = '0;
    endcase
  end
  // multiply: {hi,lo} shifts right, lo holds remaining multiplier bits
  assign mul_s = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
`ifdef CPU_ALU_DIV_EN
  logic div_q;
  logic [WIDTH:0] sh, dif;
  // divide: hi is the partial remainder, lo shifts dividend out and quotient in
  assign sh = {hi, lo[WIDTH-1]};
  assign dif = sh - {1'b0, b};
  assign hi_n = div_q ? (dif[WIDTH] ? sh[WIDTH-1:0] : dif[WIDTH-1:0]) : mul_s[WIDTH:1];
  assign lo_n = div_q ? {lo[WIDTH-2:0], !dif[WIDTH]} : {mul_s[0], lo[WIDTH-1:1]};
`else
  assign hi_n = mul_s[WIDTH:1];
  assign lo_n = {mul_s[0], lo[WIDTH-1:1]};
`endif
  assign rn = sel_hi ? hi_n : lo_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      b <= '0;
      sel_hi <= 1'b0;
`ifdef CPU_ALU_DIV_EN
      div_q <= 1'b0;
`endif
      out_r <= '0;
      out_z <= 1'b0;
      out_n <= 1'b0;
      out_c <= 1'b0;
      out_v <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && iter) begin
        cnt <= CW'(WIDTH);
        hi <= '0;
        lo <= in_op[1] ? in_x : in_y;
        b <= in_op[1] ? in_y : in_x;
        sel_hi <= in_op[0];
`ifdef CPU_ALU_DIV_EN
        div_q <= in_op[1];
`endif
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
        hi <= hi_n;
        lo <= lo_n;
      end
      if (accept && !iter) begin
        out_r <= r1;
        out_z <= r1 == '0;
        out_n <= r1[WIDTH-1];
        out_c <= c1;
        out_v <= v1;
      end else if (last) begin
        out_r <= rn;
        out_z <= rn == '0;
        out_n <= rn[WIDTH-1];
        out_c <= 1'b0;
        out_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cpu_alu_seq.sv
// tb_cpu_alu_seq: directed vectors with a result scoreboard plus timing/backpressure/reset checks.
module tb_cpu_alu_seq;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [3:0] in_op = '0;
  logic [15:0] in_x = '0, in_y = '0, out_r;
  logic out_z, out_n, out_c, out_v;
  logic [19:0] exp_q[$];
  logic [19:0] e;
  int errors = 0, checks = 0;
  cpu_alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, want);
    end
  endtask
  // expected packing: {r, z, n, c, v}
  task automatic send(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y, input logic [19:0] want);
    int n;
    n = 0;
    exp_q.push_back(want);
    in_op = op;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%b", op);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x = 16'hdead;
    in_y = 16'hbeef;
  endtask
  task automatic lat_iter(input string nm);
    logic bad;
    bad = out_valid | in_ready;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1;
      bad = bad | out_valid | in_ready;
    end
    chk({nm, "_busy"}, {31'd0, bad}, 32'd0);
    @(posedge clk);
    #1;
    chk({nm, "_lat16"}, {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk({nm, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got=%h exp=none", {out_r, out_z, out_n, out_c, out_v});
      end else begin
        e = exp_q.pop_front();
        if ({out_r, out_z, out_n, out_c, out_v} !== e) begin
          errors++;
          $display("FAIL result got=%h exp=%h", {out_r, out_z, out_n, out_c, out_v}, e);
        end
      end
    end
  end
  initial begin
    logic stale;
    int n;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {11'd0, out_r, out_z, out_n, out_c, out_v}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_ready", {31'd0, in_ready}, 32'd1);
    send(4'b0100, 16'hffff, 16'h0001, {16'h0000, 4'b1010});
    chk("add_lat1", {31'd0, out_valid}, 32'd1);
    send(4'b0101, 16'h8000, 16'h0001, {16'h7fff, 4'b0001});
    send(4'b0100, 16'h7fff, 16'h0001, {16'h8000, 4'b0101});
    send(4'b0101, 16'h0001, 16'h0002, {16'hffff, 4'b0110});
    send(4'b0000, 16'hf0f0, 16'h0ff0, {16'h00f0, 4'b0000});
    send(4'b0001, 16'hf000, 16'h000f, {16'hf00f, 4'b0100});
    send(4'b0010, 16'hffff, 16'hffff, {16'h0000, 4'b1000});
    send(4'b0011, 16'h00ff, 16'h1234, {16'hff00, 4'b0100});
    send(4'b0110, 16'h8000, 16'h0001, {16'h0001, 4'b0000});
    send(4'b0111, 16'h8000, 16'h0001, {16'h0000, 4'b1000});
    send(4'b1011, 16'h1234, 16'h0004, {16'h4123, 4'b0000});
    send(4'b1000, 16'h0001, 16'h000f, {16'h8000, 4'b0100});
    send(4'b1001, 16'habcd, 16'h0010, {16'habcd, 4'b0100});
    send(4'b1010, 16'h8001, 16'h0001, {16'h0003, 4'b0000});
    send(4'b1001, 16'h8000, 16'h000f, {16'h0001, 4'b0000});
    @(posedge clk);
    #1;
    chk("idle_drop", {31'd0, out_valid}, 32'd0);
    send(4'b1100, 16'h1234, 16'h0010, {16'h2340, 4'b0000});
    lat_iter("mul");
    send(4'b1101, 16'hffff, 16'hffff, {16'hfffe, 4'b0100});
    lat_iter("mulhu");
    send(4'b1100, 16'hffff, 16'hffff, {16'h0001, 4'b0000});
    lat_iter("mul_lo");
    out_ready = 1'b0;
    send(4'b0100, 16'h1234, 16'h1111, {16'h2345, 4'b0000});
    exp_q.push_back({16'h4000, 4'b0000});
    in_op = 4'b0101;
    in_x = 16'h5000;
    in_y = 16'h1000;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", {11'd0, out_valid, out_r, out_z, out_n, out_c, out_v}, {11'd0, 1'b1, 16'h2345, 4'b0000});
      chk("bp_no_accept", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_sub", {15'd0, out_valid, out_r}, {15'd0, 1'b1, 16'h4000});
`ifdef CPU_ALU_DIV_EN
    send(4'b1110, 16'd100, 16'd7, {16'h000e, 4'b0000});
    lat_iter("divu");
    send(4'b1111, 16'd100, 16'd7, {16'h0002, 4'b0000});
    lat_iter("remu");
    send(4'b1110, 16'h1234, 16'h0000, {16'hffff, 4'b0100});
    lat_iter("divu0");
    send(4'b1111, 16'h1234, 16'h0000, {16'h1234, 4'b0000});
    lat_iter("remu0");
`else
    send(4'b1110, 16'd100, 16'd7, {16'h0000, 4'b1000});
    chk("divu_nodiv_lat1", {31'd0, out_valid}, 32'd1);
    send(4'b1111, 16'd100, 16'd7, {16'h0000, 4'b1000});
    chk("remu_nodiv_lat1", {31'd0, out_valid}, 32'd1);
`endif
    send(4'b1100, 16'h0003, 16'h0005, {16'h000f, 4'b0000});
    exp_q.delete(exp_q.size() - 1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_release_ready", {31'd0, in_ready}, 32'd1);
    stale = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      stale = stale | out_valid;
    end
    chk("midrst_no_stale", {31'd0, stale}, 32'd0);
    send(4'b0100, 16'h0002, 16'h0003, {16'h0005, 4'b0000});
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_alu_seq.md
# cpu_alu_seq

Parametrised, handshaked successor to the CPU's 16-bit combinational ALU. It generalises the datapath to WIDTH bits and registers every result. It adds full-range shifts/rotates and condition flags, plus an iterative multiplier and an optional iterative unsigned divider. It sits in the CPU execute stage and is driven by the decoder through a valid/ready request port and a valid/ready result port.

## Interface
- WIDTH, 16: datapath width; power of two, 8..64. SHW = $clog2(WIDTH).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted on an edge where in_valid & in_ready.
- in_op  in  4  operation code.
- in_x, in_y  in  WIDTH  operands.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result on an edge where out_valid & out_ready.
- out_r  out  WIDTH  result.
- out_z, out_n, out_c, out_v  out  1 each  zero, negative, carry/borrow, signed overflow.

## Operation
- Ops (x=in_x, y=in_y, modulo 2^WIDTH):
  - 0000 AND; 0001 OR; 0010 XOR; 0011 NOT x.
  - 0100 ADD; 0101 SUB.
  - 0110 SLT signed, result 0 or 1; 0111 SLTU, result 0 or 1.
  - 1000 SHL; 1001 SHR logical; 1010 ROL; 1011 ROR. Amount is y[SHW-1:0]; amount 0 returns x.
  - 1100 MUL, low WIDTH bits of x*y; 1101 MULHU, high WIDTH bits of unsigned x*y.
  - 1110 DIVU quotient; 1111 REMU remainder.
- Class: ops 0000-1011 are single-cycle. 1100/1101 are iterative (shift-add, one bit per cycle). 1110/1111 are iterative (restoring division, one bit per cycle).
- Flags:
  - z = (r==0); n = r[WIDTH-1], for every op.
  - c = carry-out for ADD, borrow (x<y unsigned) for SUB, 0 otherwise.
  - v = signed overflow for ADD/SUB, 0 otherwise.
- Divide by zero: DIVU returns all ones; REMU returns x. Both have normal iterative latency.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept single-cycle op → DONE with result registered. Accept iterative op → BUSY, operands latched, counter = WIDTH.
  - BUSY: one step per edge, counter decrements; on the edge where counter goes 1→0 → DONE with result registered.
  - DONE: out_valid=1. If out_ready: a simultaneously accepted new request is handled exactly as from IDLE; otherwise → IDLE.
- in_ready = !reset & (state==IDLE | (state==DONE & out_ready)). Combinational from out_ready; no combinational path from in_* to out_*.
- out_r and flags are held stable while out_valid & !out_ready. Operands are latched at accept; in_x/in_y may change afterwards.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; out_valid=0; out_r=0; all flags 0; counter=0.
  - in_ready=0 while reset is asserted, 1 from the first cycle after deassertion.
- Single-cycle op: request accepted at edge N gives out_valid=1 after edge N.
- Iterative op: request accepted at edge N gives out_valid=1 after edge N+WIDTH; in_ready=0 throughout BUSY.
- Throughput: back-to-back single-cycle ops sustain one result per cycle while out_ready=1.
- Reset mid-BUSY or mid-DONE: partial/pending result is discarded; no out_valid after reset deasserts until a new request completes.
- in_valid=0 in DONE with out_ready=1 returns to IDLE; out_valid drops after that edge.

## Configuration
- CPU_ALU_DIV_EN defined: divider datapath present; ops 1110/1111 behave as above.
- CPU_ALU_DIV_EN undefined: no divider logic. Ops 1110/1111 complete as single-cycle ops with r=0, z=1, n=c=v=0.

## Test plan
- Single-cycle ADD:
  - ADD x=0xFFFF y=0x0001 → r=0x0000 z=1 c=1 v=0, out_valid one edge after accept.
  - SUB x=0x8000 y=0x0001 → r=0x7FFF v=1 c=0 n=0.
- Shifts: ROR x=0x1234 y=4 → 0x4123; SHL x=0x0001 y=15 → 0x8000; SHR y=0x0010 (amount 0) → x unchanged.
- MUL x=0x1234 y=0x0010 → 0x2340; MULHU x=0xFFFF y=0xFFFF → 0xFFFE. out_valid exactly 16 edges after accept; in_ready=0 during BUSY.
- Backpressure:
  - out_ready=0 for 5 cycles after ADD result → out_r/flags stable; a queued SUB is not accepted.
  - Raise out_ready → SUB accepted on the same edge; its result appears next cycle.
- Divider, with CPU_ALU_DIV_EN:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU 0x1234/0 → 0xFFFF; REMU 0x1234/0 → 0x1234.
  - Without macro: DIVU → 0 with z=1 after 1 edge.
- Reset asserted 5 cycles into a MUL → out_valid=0 immediately; in_ready=1 the cycle after deassertion; no stale result appears.
